// File: rtl/linescanner_multichannel_capture_unit.sv
`default_nettype none
//==============================================================================
// Module   : linescanner_multichannel_capture_unit
// Brief    : Multi-channel line-scan capture sequencer: load/reset/CDS/sample
//            strobes per pixel, ADC word capture, line markers, timeouts.
// Revision : 1.0 - initial release
//==============================================================================
module linescanner_multichannel_capture_unit #(
    parameter int DATA_WIDTH      = 8,
    parameter int CHANNELS        = 2,
    parameter int PIXELS_PER_LINE = 1024,
    parameter int LOAD_CYCLES     = 4,
    parameter int RST_CVC_CYCLES  = 4,
    parameter int RST_CDS_CYCLES  = 4,
    parameter int SAMPLE_CYCLES   = 4,
    parameter int ADC_TIMEOUT     = 64,
    parameter int LVAL_TIMEOUT    = 4096
) (
    input  logic                                main_clock,
    input  logic                                reset,
    input  logic                                enable,
    input  logic                                lval,
    input  logic                                end_adc,
    input  logic [CHANNELS*DATA_WIDTH-1:0]      data,
    output logic                                load_pulse,
    output logic                                rst_cvc,
    output logic                                rst_cds,
    output logic                                sample,
    output logic [CHANNELS*DATA_WIDTH-1:0]      pixel_data,
    output logic                                pixel_valid,
    output logic [$clog2(PIXELS_PER_LINE)-1:0]  pixel_index,
    output logic                                line_end,
    output logic [15:0]                         line_count,
    output logic                                error
);

    localparam int c_DW      = CHANNELS * DATA_WIDTH;
    localparam int c_IDX_W   = $clog2(PIXELS_PER_LINE);
    localparam int c_MAX_A   = (LOAD_CYCLES    > RST_CVC_CYCLES) ? LOAD_CYCLES    : RST_CVC_CYCLES;
    localparam int c_MAX_B   = (RST_CDS_CYCLES > SAMPLE_CYCLES)  ? RST_CDS_CYCLES : SAMPLE_CYCLES;
    localparam int c_MAX_C   = (ADC_TIMEOUT    > LVAL_TIMEOUT)   ? ADC_TIMEOUT    : LVAL_TIMEOUT;
    localparam int c_MAX_AB  = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_MAX = (c_MAX_AB > c_MAX_C) ? c_MAX_AB : c_MAX_C;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_LOAD_LAST = c_CNT_W'(LOAD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CVC_LAST  = c_CNT_W'(RST_CVC_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CDS_LAST  = c_CNT_W'(RST_CDS_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SMP_LAST  = c_CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ADC_LAST  = c_CNT_W'(ADC_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_LVAL_LAST = c_CNT_W'(LVAL_TIMEOUT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(PIXELS_PER_LINE - 1);

    localparam logic [3:0] c_S_IDLE      = 4'd0;
    localparam logic [3:0] c_S_LOAD      = 4'd1;
    localparam logic [3:0] c_S_WAIT_LVAL = 4'd2;
    localparam logic [3:0] c_S_RST_CVC   = 4'd3;
    localparam logic [3:0] c_S_RST_CDS   = 4'd4;
    localparam logic [3:0] c_S_SAMPLE    = 4'd5;
    localparam logic [3:0] c_S_WAIT_ADC  = 4'd6;
    localparam logic [3:0] c_S_CAPTURE   = 4'd7;
    localparam logic [3:0] c_S_LINE_DONE = 4'd8;

    logic [3:0]         r_state;
    logic [3:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_end_adc_q;
    logic               w_adc_rise;
    logic [c_IDX_W-1:0] r_index;
    logic [c_DW-1:0]    r_pixel_data;
    logic [15:0]        r_line_count;
    logic               r_error;
    logic               w_err_set;
    logic               w_idx_clr;
    logic               w_idx_inc;
    logic               w_capture;

    assign w_adc_rise = end_adc & ~r_end_adc_q;

    // Counter restarts on every state change so each strobe width is exact.
    always_ff @(posedge main_clock) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if ((w_state_next != r_state) || (r_state == c_S_IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err_set    = 1'b0;
        w_idx_clr    = 1'b0;
        w_idx_inc    = 1'b0;
        w_capture    = 1'b0;
        load_pulse   = 1'b0;
        rst_cvc      = 1'b0;
        rst_cds      = 1'b0;
        sample       = 1'b0;
        pixel_valid  = 1'b0;
        line_end     = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (enable) begin
                    w_state_next = c_S_LOAD;
                end
            end
            c_S_LOAD: begin
                load_pulse = 1'b1;
                if (r_cnt == c_LOAD_LAST) begin
                    w_state_next = c_S_WAIT_LVAL;
                end
            end
            c_S_WAIT_LVAL: begin
                if (lval) begin
                    w_state_next = c_S_RST_CVC;
                    w_idx_clr    = 1'b1;
                end else if (r_cnt == c_LVAL_LAST) begin
                    w_state_next = c_S_IDLE;
                    w_err_set    = 1'b1;
                end
            end
            c_S_RST_CVC: begin
                rst_cvc = 1'b1;
                if (r_cnt == c_CVC_LAST) begin
                    w_state_next = c_S_RST_CDS;
                end
            end
            c_S_RST_CDS: begin
                rst_cds = 1'b1;
                if (r_cnt == c_CDS_LAST) begin
                    w_state_next = c_S_SAMPLE;
                end
            end
            c_S_SAMPLE: begin
                sample = 1'b1;
                if (r_cnt == c_SMP_LAST) begin
                    w_state_next = c_S_WAIT_ADC;
                end
            end
            c_S_WAIT_ADC: begin
                if (w_adc_rise) begin
                    w_state_next = c_S_CAPTURE;
                    w_capture    = 1'b1;
                end else if (r_cnt == c_ADC_LAST) begin
                    // An aborted conversion still closes the line for downstream.
                    w_state_next = c_S_LINE_DONE;
                    w_err_set    = 1'b1;
                end
            end
            c_S_CAPTURE: begin
                pixel_valid = 1'b1;
                if ((r_index == c_IDX_LAST) || !lval) begin
                    w_state_next = c_S_LINE_DONE;
                end else begin
                    w_state_next = c_S_RST_CVC;
                    w_idx_inc    = 1'b1;
                end
            end
            c_S_LINE_DONE: begin
                line_end     = 1'b1;
                w_state_next = enable ? c_S_LOAD : c_S_IDLE;
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge main_clock) begin
        if (reset) begin
            r_end_adc_q  <= 1'b0;
            r_index      <= '0;
            r_pixel_data <= '0;
            r_line_count <= '0;
            r_error      <= 1'b0;
        end else begin
            r_end_adc_q <= end_adc;
            if (w_idx_clr) begin
                r_index <= '0;
            end else if (w_idx_inc) begin
                r_index <= r_index + c_IDX_W'(1);
            end
            // Data is taken on the clock that sees the end_adc rise.
            if (w_capture) begin
                r_pixel_data <= data;
            end
            if (r_state == c_S_LINE_DONE) begin
                r_line_count <= r_line_count + 16'd1;
            end
            if (w_err_set) begin
                r_error <= 1'b1;
            end
        end
    end

    assign pixel_data  = r_pixel_data;
    assign pixel_index = r_index;
    assign line_count  = r_line_count;
    assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_linescanner_multichannel_capture_unit.sv
`default_nettype none
//==============================================================================
// Module   : tb_linescanner_multichannel_capture_unit
// Brief    : Self-checking bench with an ADC/sensor responder and event log.
// Revision : 1.0 - initial release
//==============================================================================
module tb_linescanner_multichannel_capture_unit;

    localparam int c_DW      = 8;
    localparam int c_CH      = 2;
    localparam int c_PPL     = 4;
    localparam int c_CYC     = 2;
    localparam int c_ADC_TO  = 16;
    localparam int c_LVAL_TO = 64;
    localparam int c_W       = c_DW * c_CH;
    localparam int c_IW      = $clog2(c_PPL);

    logic            main_clock = 1'b0;
    logic            reset      = 1'b1;
    logic            enable     = 1'b0;
    logic            lval       = 1'b0;
    logic            end_adc    = 1'b0;
    logic [c_W-1:0]  data       = '0;
    logic            load_pulse, rst_cvc, rst_cds, sample;
    logic [c_W-1:0]  pixel_data;
    logic            pixel_valid;
    logic [c_IW-1:0] pixel_index;
    logic            line_end;
    logic [15:0]     line_count;
    logic            error;

    int errors = 0;
    int checks = 0;

    always #5 main_clock = ~main_clock;

    linescanner_multichannel_capture_unit #(
        .DATA_WIDTH(c_DW), .CHANNELS(c_CH), .PIXELS_PER_LINE(c_PPL),
        .LOAD_CYCLES(c_CYC), .RST_CVC_CYCLES(c_CYC), .RST_CDS_CYCLES(c_CYC),
        .SAMPLE_CYCLES(c_CYC), .ADC_TIMEOUT(c_ADC_TO), .LVAL_TIMEOUT(c_LVAL_TO)
    ) u_dut (
        .main_clock(main_clock), .reset(reset), .enable(enable), .lval(lval),
        .end_adc(end_adc), .data(data), .load_pulse(load_pulse), .rst_cvc(rst_cvc),
        .rst_cds(rst_cds), .sample(sample), .pixel_data(pixel_data),
        .pixel_valid(pixel_valid), .pixel_index(pixel_index), .line_end(line_end),
        .line_count(line_count), .error(error)
    );

    // Event log, sampled on the falling edge.
    int cyc = 0;
    int n_le = 0, n_load = 0, n_cvc = 0, n_overlap = 0;
    int load_fall_cyc = 0, smp_fall_cyc = 0, le_cyc = 0, err_rise_cyc = 0;
    int run_load = 0, run_cvc = 0, run_cds = 0, run_smp = 0;
    logic p_err = 1'b0;
    logic [c_IW-1:0] got_idx[$];
    logic [c_W-1:0]  got_dat[$];
    int              wid_q[$];

    initial begin
        forever begin
            @(negedge main_clock);
            cyc++;
            if (pixel_valid) begin
                got_idx.push_back(pixel_index);
                got_dat.push_back(pixel_data);
            end
            if (line_end) begin
                n_le++;
                le_cyc = cyc;
            end
            if (error && !p_err) err_rise_cyc = cyc;
            p_err = error;
            if (int'(load_pulse) + int'(rst_cvc) + int'(rst_cds) + int'(sample) > 1) n_overlap++;
            if (load_pulse) begin
                if (run_load == 0) n_load++;
                run_load++;
            end else if (run_load > 0) begin
                wid_q.push_back(run_load); run_load = 0; load_fall_cyc = cyc;
            end
            if (rst_cvc) begin
                if (run_cvc == 0) n_cvc++;
                run_cvc++;
            end else if (run_cvc > 0) begin
                wid_q.push_back(run_cvc); run_cvc = 0;
            end
            if (rst_cds) run_cds++;
            else if (run_cds > 0) begin
                wid_q.push_back(run_cds); run_cds = 0;
            end
            if (sample) run_smp++;
            else if (run_smp > 0) begin
                wid_q.push_back(run_smp); run_smp = 0; smp_fall_cyc = cyc;
            end
        end
    end

    // ADC responder: answers each sample fall with an end_adc rise and a word.
    logic           adc_auto  = 1'b0;
    bit             adc_fixed = 1'b0;
    logic [c_W-1:0] exp_dat[$];

    initial begin
        int dly;
        int hold;
        bit pend;
        logic p_s;
        logic [c_W-1:0] pd;
        dly = 0; hold = 0; pend = 0; p_s = 1'b0; pd = '0;
        forever begin
            @(posedge main_clock);
            #1;
            if (!adc_auto) pend = 0;
            if (hold > 0) begin
                hold--;
                if (hold == 0) end_adc = 1'b0;
            end
            if (pend) begin
                if (dly == 0) begin
                    end_adc = 1'b1; data = pd; exp_dat.push_back(pd); hold = 2; pend = 0;
                end else begin
                    dly--;
                end
            end
            if (p_s && !sample && adc_auto) begin
                pend = 1;
                dly  = adc_fixed ? 4 : int'($urandom_range(0, 9));
                pd   = adc_fixed ? 16'hFF01 : c_W'($urandom);
            end
            p_s = sample;
        end
    end

    task automatic tick();
        @(posedge main_clock);
        #2;
    endtask

    task automatic clear_log();
        n_le = 0; n_load = 0; n_cvc = 0; n_overlap = 0;
        got_idx.delete(); got_dat.delete(); wid_q.delete(); exp_dat.delete();
    endtask

    task automatic do_reset();
        adc_auto = 1'b0; enable = 1'b0; lval = 1'b0; end_adc = 1'b0; data = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        clear_log();
    endtask

    function automatic int get_cnt(input int which);
        case (which)
            0: return n_le;
            1: return n_load;
            2: return got_idx.size();
            3: return int'(error);
            default: return int'(sample);
        endcase
    endfunction

    task automatic wait_cnt(input int which, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (get_cnt(which) >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; lval = 1'b0;
        repeat (3) tick();
        checks++; if ({load_pulse, rst_cvc, rst_cds, sample} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {load_pulse, rst_cvc, rst_cds, sample}); end
        checks++; if ({pixel_valid, line_end, error} !== 3'b0) begin errors++; $display("FAIL reset_flags: got %b expected 000", {pixel_valid, line_end, error}); end
        checks++; if (pixel_data !== '0) begin errors++; $display("FAIL reset_pixel_data: got %h expected 0", pixel_data); end
        checks++; if (line_count !== 16'd0) begin errors++; $display("FAIL reset_line_count: got %0d expected 0", line_count); end
        checks++; if (pixel_index !== '0) begin errors++; $display("FAIL reset_index: got %0d expected 0", pixel_index); end
        reset = 1'b0;
        clear_log();
        repeat (6) tick();
        checks++; if (n_load !== 0) begin errors++; $display("FAIL idle_no_load: got %0d expected 0", n_load); end
    endtask

    task automatic test_single_line();
        bit ok;
        do_reset();
        adc_fixed = 1'b1; adc_auto = 1'b1; enable = 1'b1;
        wait_cnt(1, 1, 10, ok);
        enable = 1'b0;
        for (int i = 0; i < 10 && load_pulse; i++) tick();
        lval = 1'b1;
        wait_cnt(0, 1, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_line_end_timeout: got 0 expected 1"); end
        repeat (5) tick();
        checks++; if (got_idx.size() != c_PPL) begin errors++; $display("FAIL single_pixels: got %0d expected %0d", got_idx.size(), c_PPL); end
        for (int i = 0; i < got_idx.size(); i++) begin
            checks++; if (got_idx[i] !== c_IW'(i)) begin errors++; $display("FAIL single_index[%0d]: got %0d expected %0d", i, got_idx[i], i); end
            checks++; if (got_dat[i] !== 16'hFF01) begin errors++; $display("FAIL single_data[%0d]: got %h expected ff01", i, got_dat[i]); end
        end
        checks++; if (n_le != 1) begin errors++; $display("FAIL single_line_end_count: got %0d expected 1", n_le); end
        checks++; if (line_count !== 16'd1) begin errors++; $display("FAIL single_line_count: got %0d expected 1", line_count); end
        checks++; if (wid_q.size() != 1 + 3 * c_PPL) begin errors++; $display("FAIL single_strobe_count: got %0d expected %0d", wid_q.size(), 1 + 3 * c_PPL); end
        foreach (wid_q[i]) begin
            checks++; if (wid_q[i] != c_CYC) begin errors++; $display("FAIL single_width[%0d]: got %0d expected %0d", i, wid_q[i], c_CYC); end
        end
        checks++; if (n_overlap != 0) begin errors++; $display("FAIL single_overlap: got %0d expected 0", n_overlap); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL single_error: got %b expected 0", error); end
        adc_fixed = 1'b0;
    endtask

    task automatic test_random_lines();
        bit ok;
        do_reset();
        adc_auto = 1'b1; lval = 1'b1; enable = 1'b1;
        wait_cnt(1, 3, 400, ok);
        enable = 1'b0;
        wait_cnt(0, 3, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rand_line_end_timeout: got %0d expected 3", n_le); end
        repeat (5) tick();
        checks++; if (got_idx.size() != 3 * c_PPL || exp_dat.size() != 3 * c_PPL) begin errors++; $display("FAIL rand_pixels: got %0d/%0d expected %0d", got_idx.size(), exp_dat.size(), 3 * c_PPL); end
        for (int i = 0; i < got_idx.size() && i < exp_dat.size(); i++) begin
            checks++; if (got_idx[i] !== c_IW'(i % c_PPL)) begin errors++; $display("FAIL rand_index[%0d]: got %0d expected %0d", i, got_idx[i], i % c_PPL); end
            checks++; if (got_dat[i] !== exp_dat[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, got_dat[i], exp_dat[i]); end
        end
        checks++; if (line_count !== 16'd3) begin errors++; $display("FAIL rand_line_count: got %0d expected 3", line_count); end
        checks++; if (n_overlap != 0) begin errors++; $display("FAIL rand_overlap: got %0d expected 0", n_overlap); end
        foreach (wid_q[i]) begin
            checks++; if (wid_q[i] != c_CYC) begin errors++; $display("FAIL rand_width[%0d]: got %0d expected %0d", i, wid_q[i], c_CYC); end
        end
    endtask

    task automatic test_lval_drop();
        bit ok;
        int exp_idx[6] = '{0, 1, 0, 1, 2, 3};
        do_reset();
        adc_auto = 1'b1; lval = 1'b1; enable = 1'b1;
        wait_cnt(2, 1, 100, ok);
        tick();
        lval = 1'b0;
        wait_cnt(0, 1, 100, ok);
        tick();
        checks++; if (got_idx.size() != 2) begin errors++; $display("FAIL drop_first_line_pixels: got %0d expected 2", got_idx.size()); end
        wait_cnt(1, 2, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_new_load: got %0d expected 2", n_load); end
        enable = 1'b0; lval = 1'b1;
        wait_cnt(0, 2, 300, ok);
        repeat (3) tick();
        checks++; if (got_idx.size() != 6 || exp_dat.size() != 6) begin errors++; $display("FAIL drop_pixels: got %0d/%0d expected 6", got_idx.size(), exp_dat.size()); end
        for (int i = 0; i < 6 && i < got_idx.size() && i < exp_dat.size(); i++) begin
            checks++; if (got_idx[i] !== c_IW'(exp_idx[i])) begin errors++; $display("FAIL drop_index[%0d]: got %0d expected %0d", i, got_idx[i], exp_idx[i]); end
            checks++; if (got_dat[i] !== exp_dat[i]) begin errors++; $display("FAIL drop_data[%0d]: got %h expected %h", i, got_dat[i], exp_dat[i]); end
        end
        checks++; if (line_count !== 16'd2) begin errors++; $display("FAIL drop_line_count: got %0d expected 2", line_count); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL drop_error: got %b expected 0", error); end
    endtask

    task automatic test_adc_timeout();
        bit ok;
        do_reset();
        lval = 1'b1; enable = 1'b1;
        wait_cnt(0, 1, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL adc_to_line_end: got 0 expected 1"); end
        checks++; if (got_idx.size() != 0) begin errors++; $display("FAIL adc_to_pixels: got %0d expected 0", got_idx.size()); end
        checks++; if (le_cyc - smp_fall_cyc != c_ADC_TO) begin errors++; $display("FAIL adc_to_delay: got %0d expected %0d", le_cyc - smp_fall_cyc, c_ADC_TO); end
        checks++; if (err_rise_cyc != le_cyc) begin errors++; $display("FAIL adc_to_error_timing: got %0d expected %0d", err_rise_cyc, le_cyc); end
        checks++; if (n_cvc != 1) begin errors++; $display("FAIL adc_to_cvc_count: got %0d expected 1", n_cvc); end
        adc_auto = 1'b1;
        wait_cnt(1, 2, 20, ok);
        enable = 1'b0;
        wait_cnt(0, 2, 300, ok);
        repeat (3) tick();
        checks++; if (got_idx.size() != c_PPL || exp_dat.size() != c_PPL) begin errors++; $display("FAIL adc_to_next_line: got %0d/%0d expected %0d", got_idx.size(), exp_dat.size(), c_PPL); end
        for (int i = 0; i < got_idx.size() && i < exp_dat.size(); i++) begin
            checks++; if (got_dat[i] !== exp_dat[i] || got_idx[i] !== c_IW'(i)) begin errors++; $display("FAIL adc_to_pixel[%0d]: got %0d:%h expected %0d:%h", i, got_idx[i], got_dat[i], i, exp_dat[i]); end
        end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL adc_to_error_sticky: got %b expected 1", error); end
        checks++; if (line_count !== 16'd2) begin errors++; $display("FAIL adc_to_line_count: got %0d expected 2", line_count); end
    endtask

    task automatic test_lval_timeout();
        bit ok;
        do_reset();
        enable = 1'b1;
        wait_cnt(1, 1, 10, ok);
        enable = 1'b0;
        wait_cnt(3, 1, 120, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lval_to_error: got 0 expected 1"); end
        tick();
        checks++; if (err_rise_cyc - load_fall_cyc != c_LVAL_TO) begin errors++; $display("FAIL lval_to_delay: got %0d expected %0d", err_rise_cyc - load_fall_cyc, c_LVAL_TO); end
        checks++; if (n_cvc != 0 || n_le != 0) begin errors++; $display("FAIL lval_to_activity: got cvc=%0d le=%0d expected 0 0", n_cvc, n_le); end
        repeat (20) tick();
        checks++; if (n_load != 1) begin errors++; $display("FAIL lval_to_idle: got %0d loads expected 1", n_load); end
        enable = 1'b1;
        wait_cnt(1, 2, 4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lval_to_reenable: got %0d loads expected 2", n_load); end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        bit ok;
        do_reset();
        adc_auto = 1'b1; lval = 1'b1; enable = 1'b1;
        wait_cnt(2, 2, 100, ok);
        enable = 1'b0;
        wait_cnt(0, 1, 100, ok);
        repeat (10) tick();
        checks++; if (got_idx.size() != c_PPL || n_load != 1) begin errors++; $display("FAIL endrop_pixels: got %0d px %0d loads expected %0d px 1 load", got_idx.size(), n_load, c_PPL); end
        checks++; if ({load_pulse, rst_cvc, rst_cds, sample, pixel_valid, line_end} !== 6'b0) begin errors++; $display("FAIL endrop_quiet: got %b expected 000000", {load_pulse, rst_cvc, rst_cds, sample, pixel_valid, line_end}); end
        checks++; if (line_count !== 16'd1) begin errors++; $display("FAIL endrop_line_count: got %0d expected 1", line_count); end
        enable = 1'b1;
        wait_cnt(1, 2, 4, ok);
        checks++; if (!ok) begin errors++; $display("FAIL endrop_restart: got %0d loads expected 2", n_load); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_cnt(4, 1, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_sample: got 0 expected 1"); end
        adc_auto = 1'b0; enable = 1'b0; reset = 1'b1;
        tick();
        checks++; if ({load_pulse, rst_cvc, rst_cds, sample, pixel_valid, line_end} !== 6'b0) begin errors++; $display("FAIL rstmid_outputs: got %b expected 000000", {load_pulse, rst_cvc, rst_cds, sample, pixel_valid, line_end}); end
        checks++; if (line_count !== 16'd0 || error !== 1'b0) begin errors++; $display("FAIL rstmid_counters: got lc=%0d err=%b expected 0 0", line_count, error); end
        reset = 1'b0;
        clear_log();
        tick();
        data = 16'hA5C3; end_adc = 1'b1;
        repeat (3) tick();
        end_adc = 1'b0;
        repeat (5) tick();
        checks++; if (got_idx.size() != 0 || pixel_data !== '0) begin errors++; $display("FAIL rstmid_idle_adc: got %0d px data %h expected 0 px data 0", got_idx.size(), pixel_data); end
        checks++; if (n_load != 0 || n_cvc != 0) begin errors++; $display("FAIL rstmid_idle_strobes: got load=%0d cvc=%0d expected 0 0", n_load, n_cvc); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_line();
        test_random_lines();
        test_lval_drop();
        test_adc_timeout();
        test_lval_timeout();
        test_enable_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
